// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a clock-enabled byte FIFO and sends each byte
// as a start bit, 8 data bits LSB first, then STOP_BITS stop bits.
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             txd,
    output logic             busy,
    output logic             tx_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]       r_state;
    logic [7:0]       r_shreg;
    logic [DIV_W-1:0] r_div_lat;
    logic [DIV_W-1:0] r_timer;
    logic [2:0]       r_bit_cnt;
    logic [0:0]       r_stop_cnt;
    logic             r_txd;

    logic [2:0]       w_next_state;
    logic [7:0]       w_next_shreg;
    logic             w_next_txd;
    logic             w_bit_end;
    logic             w_last_stop;

    assign w_bit_end   = (r_timer == '0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end &&
                         (r_stop_cnt == 1'(STOP_BITS - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_shreg = r_shreg;
        case (r_state)
            S_IDLE:  if (!fifo_empty) w_next_state = S_PRIME;
            S_PRIME: w_next_state = fifo_empty ? S_IDLE : S_LOAD;
            S_LOAD: begin
                w_next_state = S_START;
                w_next_shreg = fifo_data;
            end
            S_START: if (w_bit_end) w_next_state = S_DATA;
            S_DATA: if (w_bit_end) begin
                w_next_shreg = r_shreg >> 1;
                if (r_bit_cnt == 3'd7) w_next_state = S_STOP;
            end
            S_STOP: if (w_last_stop) w_next_state = fifo_empty ? S_IDLE : S_PRIME;
            default: w_next_state = S_IDLE;
        endcase
    end

    // txd is registered from the next state, so the line level always belongs
    // to the state the frame is entering.
    always_comb begin
        case (w_next_state)
            S_START: w_next_txd = 1'b0;
            S_DATA:  w_next_txd = w_next_shreg[0];
            default: w_next_txd = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_div_lat  <= '0;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_txd      <= 1'b1;
        end else if (clk_en) begin
            r_state <= w_next_state;
            r_shreg <= w_next_shreg;
            r_txd   <= w_next_txd;
            case (r_state)
                S_LOAD: begin
                    r_div_lat  <= baud_div;
                    r_timer    <= baud_div;
                    r_bit_cnt  <= '0;
                    r_stop_cnt <= '0;
                end
                S_START, S_DATA, S_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= r_div_lat;
                        if (r_state == S_DATA) r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_state == S_STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
                    end else begin
                        r_timer <= r_timer - DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd_en = clk_en && (r_state == S_LOAD);
    assign busy       = (r_state == S_LOAD) || (r_state == S_START) ||
                        (r_state == S_DATA) || (r_state == S_STOP);
    assign tx_done    = clk_en && w_last_stop;
    assign txd        = r_txd;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, and a frame
// model predicts txd/busy/tx_done/fifo_rd_en for every clk_en cycle.
`timescale 1ns/1ps

module tb_fifo_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [15:0] baud_div;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        sel;

    logic rst1, rst2;
    logic rd1, txd1, busy1, done1;
    logic rd2, txd2, busy2, done2;
    logic fifo_rd_en, txd, busy, tx_done;

    always #5 clk = ~clk;

    // The unselected instance is held in reset; both see the same FIFO.
    assign rst1 = reset | sel;
    assign rst2 = reset | ~sel;

    fifo_uart_tx #(.STOP_BITS(1), .DIV_W(16)) u_dut1 (
        .clk(clk), .reset(rst1), .clk_en(clk_en), .baud_div(baud_div),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd1), .txd(txd1), .busy(busy1), .tx_done(done1)
    );

    fifo_uart_tx #(.STOP_BITS(2), .DIV_W(16)) u_dut2 (
        .clk(clk), .reset(rst2), .clk_en(clk_en), .baud_div(baud_div),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd2), .txd(txd2), .busy(busy2), .tx_done(done2)
    );

    assign fifo_rd_en = sel ? rd2   : rd1;
    assign txd        = sel ? txd2  : txd1;
    assign busy       = sel ? busy2 : busy1;
    assign tx_done    = sel ? done2 : done1;

    typedef struct packed {
        logic txd;
        logic busy;
        logic done;
        logic rd;
    } obs_t;

    localparam obs_t IDLE_O = 4'b1000;

    obs_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] frame_bytes[$];
    int         frame_divs[$];
    int errors = 0, checks = 0, pops = 0, dones = 0, cyc = 0, ce_mode = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic obs_t mk(input logic t, input logic b, input logic d, input logic r);
        return {t, b, d, r};
    endfunction

    // One IDLE cycle when the FIFO turns non-empty, then per byte: PRIME, LOAD
    // (pop), and the frame bits each held div+1 clk_en cycles.
    task automatic build_expect(input int stop);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < frame_bytes.size(); i++) begin
            logic [7:0] b;
            int nbits;
            b = frame_bytes[i];
            nbits = 9 + stop;
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
            for (int k = 0; k < nbits; k++) begin
                logic bitv;
                if (k == 0)      bitv = 1'b0;
                else if (k <= 8) bitv = b[k-1];
                else             bitv = 1'b1;
                for (int r = 0; r <= frame_divs[i]; r++)
                    exp_q.push_back(mk(bitv, 1'b1, (k == nbits - 1) && (r == frame_divs[i]), 1'b0));
            end
        end
    endtask

    function automatic bit gen_ce();
        case (ce_mode)
            0:       return 1'b1;
            1:       return (cyc % 4) == 0;
            default: return $urandom_range(0, 2) != 0;
        endcase
    endfunction

    task automatic tick(input bit ce, input bit chk);
        obs_t o, e;
        logic rd_s;
        @(negedge clk);
        clk_en = ce;
        #1;
        o = {txd, busy, tx_done, fifo_rd_en};
        if (chk) begin
            if (ce) e = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_O;
            else    e = (exp_q.size() != 0) ? mk(exp_q[0].txd, exp_q[0].busy, 1'b0, 1'b0) : IDLE_O;
            check($sformatf("txd@%0d", cyc),     o.txd,  e.txd);
            check($sformatf("busy@%0d", cyc),    o.busy, e.busy);
            check($sformatf("tx_done@%0d", cyc), o.done, e.done);
            check($sformatf("rd_en@%0d", cyc),   o.rd,   e.rd);
            if (o.done) dones++;
        end
        rd_s = fifo_rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (ce) begin
            if (rd_s) begin
                pops++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (fifo_q.size() != 0) fifo_data = fifo_q[0];
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b, input int d);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
        frame_bytes.push_back(b);
        frame_divs.push_back(d);
    endtask

    task automatic start_test(input bit s);
        sel = s;
        reset = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        frame_bytes.delete();
        frame_divs.delete();
        pops = 0;
        dones = 0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin
            tick(gen_ce(), 1'b1);
            guard++;
        end
        check({tag, "_timeout"}, guard < 20000, 1);
        for (int i = 0; i < 4; i++) tick(gen_ce(), 1'b1);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; baud_div = '0;
        fifo_empty = 1'b1; fifo_data = '0; sel = 1'b0;

        // Reset state
        start_test(1'b0);
        tick(1'b1, 1'b1);

        // Single byte 0xA5, 4 clk per bit
        start_test(1'b0);
        ce_mode = 0; baud_div = 16'd3;
        push(8'hA5, 3);
        build_expect(1);
        drain("t1");
        check("t1_pops", pops, 1);
        check("t1_dones", dones, 1);

        // Back-to-back bytes at one clk per bit
        start_test(1'b0);
        baud_div = 16'd0;
        push(8'h00, 0); push(8'hFF, 0); push(8'h3C, 0);
        build_expect(1);
        drain("t2");
        check("t2_pops", pops, 3);
        check("t2_empty", fifo_empty, 1);

        // Sparse clock enable
        start_test(1'b0);
        ce_mode = 1; baud_div = 16'd1;
        push(8'h81, 1);
        build_expect(1);
        drain("t3");
        check("t3_dones", dones, 1);

        // Two stop bits
        start_test(1'b1);
        ce_mode = 0; baud_div = 16'd2;
        push(8'h55, 2); push(8'h0F, 2);
        build_expect(2);
        drain("t4");
        check("t4_pops", pops, 2);

        // Reset during data bit 4; the next byte must still go out intact
        start_test(1'b0);
        baud_div = 16'd1;
        push(8'hF0, 1); push(8'h3C, 1);
        build_expect(1);
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b1);
        reset = 1'b1;
        tick(1'b1, 1'b0);
        reset = 1'b0;
        exp_q.delete(); frame_bytes.delete(); frame_divs.delete();
        frame_bytes.push_back(8'h3C); frame_divs.push_back(1);
        build_expect(1);
        drain("t5");
        check("t5_dones", dones, 1);
        check("t5_pops", pops, 2);

        // baud_div changed mid-frame takes effect on the next frame only
        start_test(1'b0);
        baud_div = 16'd3;
        push(8'h6B, 3); push(8'h94, 7);
        build_expect(1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
        baud_div = 16'd7;
        drain("t6");
        check("t6_dones", dones, 2);

        // Randomised frames, instance and clock-enable density
        for (int it = 0; it < 6; it++) begin
            int n, d;
            start_test(1'($urandom_range(0, 1)));
            ce_mode = $urandom_range(0, 2);
            d = $urandom_range(0, 3);
            baud_div = 16'(d);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) push(8'($urandom), d);
            build_expect(sel ? 2 : 1);
            drain($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_pops", it), pops, n);
            check($sformatf("rnd%0d_dones", it), dones, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
